lpupf_pwr_seq: RTL



---
 rtl/lpupf_pkg.sv | 22 ++
 rtl/lpupf_dly_cnt.sv | 26 ++
 rtl/lpupf_pwr_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lpupf_pkg.sv
// Shared types and constants for the lpupf power-state sequencer.
package lpupf_pkg;

  localparam int MAX_DOM   = 8;
  localparam int DOM_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISO,
    SAVE,
    OFF,
    ON,
    REST,
    DEISO,
    DONE
  } seq_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lpupf_dly_cnt.sv
// Loadable down-counter; holds at zero and flags expiry there.
module lpupf_dly_cnt #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/lpupf_pwr_seq.sv
// Power-state sequencer driving isolation, retention and power switches per domain.
// Build option: LPUPF_RET_EN enables the SAVE/REST retention steps.
//
// state | meaning
// IDLE  | waiting for a request
// ISO   | isolation asserted, settling before switch-off
// SAVE  | retention save pulse
// OFF   | switch open, waiting for power to collapse
// ON    | switch closed, waiting for supply to settle
// REST  | retention restore pulse
// DEISO | isolation released, settling
// DONE  | commit domain state, pulse done
module lpupf_pwr_seq
  import lpupf_pkg::*;
#(
  parameter int NUM_DOM = 5,
  parameter int ISO_DLY = 2,
  parameter int PWR_DLY = 4
) (
  input  logic                 i_clk_upf,
  input  logic                 i_rst_upf,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [DOM_IDX_W-1:0] i_req_dom,
  input  logic                 i_req_on,
  input  logic                 i_force_iso,
  output logic [NUM_DOM-1:0]   o_iso,
  output logic [NUM_DOM-1:0]   o_pwr_en,
  output logic [NUM_DOM-1:0]   o_save,
  output logic [NUM_DOM-1:0]   o_restore,
  output logic [NUM_DOM-1:0]   o_pwr_stat,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int CNT_W = $clog2(max2(ISO_DLY, PWR_DLY)) + 1;
  localparam logic [CNT_W-1:0] ISO_LD = CNT_W'(ISO_DLY - 1);
  localparam logic [CNT_W-1:0] PWR_LD = CNT_W'(PWR_DLY - 1);

  seq_state_t           r_state;
  logic [DOM_IDX_W-1:0] r_dom;
  logic [NUM_DOM-1:0]   r_iso, r_pwr_en, r_pwr_stat;
  logic                 r_done, r_err;
  logic                 w_accept, w_illegal, w_redundant, w_expired, w_load;
  logic [CNT_W-1:0]     w_load_val;
  logic [NUM_DOM-1:0]   w_req_mask, w_dom_mask;

  assign o_req_ready = (r_state == IDLE) && !i_rst_upf;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_illegal   = (32'(i_req_dom) >= 32'(NUM_DOM));
  assign w_req_mask  = NUM_DOM'(1) << i_req_dom;
  assign w_dom_mask  = NUM_DOM'(1) << r_dom;
  assign w_redundant = (((r_pwr_stat & w_req_mask) != '0) == i_req_on);

  // Reload on every exit into a timed state; SAVE/REST pass straight through.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = ISO_LD;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_illegal && !w_redundant) begin
          w_load     = 1'b1;
          w_load_val = i_req_on ? PWR_LD : ISO_LD;
        end
      end
      ISO:  begin w_load = w_expired; w_load_val = PWR_LD; end
      SAVE: begin w_load = 1'b1;      w_load_val = PWR_LD; end
      ON:   begin w_load = w_expired; w_load_val = ISO_LD; end
      REST: begin w_load = 1'b1;      w_load_val = ISO_LD; end
      default: ;
    endcase
  end

  lpupf_dly_cnt #(.W(CNT_W)) u_dly_cnt (
    .i_clk     (i_clk_upf),
    .i_rst     (i_rst_upf),
    .i_load    (w_load),
    .i_val     (w_load_val),
    .o_expired (w_expired)
  );

`ifdef LPUPF_RET_EN
  logic [NUM_DOM-1:0] r_save, r_restore;
  assign o_save    = r_save;
  assign o_restore = r_restore;
`else
  assign o_save    = '0;
  assign o_restore = '0;
`endif

  always_ff @(posedge i_clk_upf) begin
    if (i_rst_upf) begin
      r_state    <= IDLE;
      r_dom      <= '0;
      r_iso      <= '0;
      r_pwr_en   <= '1;
      r_pwr_stat <= '1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef LPUPF_RET_EN
      r_save     <= '0;
      r_restore  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
`ifdef LPUPF_RET_EN
      r_save    <= '0;
      r_restore <= '0;
`endif
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dom <= i_req_dom;
            if (w_illegal) begin
              r_err <= 1'b1;
            end else if (w_redundant) begin
              r_done <= 1'b1;
            end else if (i_req_on) begin
              r_pwr_en <= r_pwr_en | w_req_mask;
              r_state  <= ON;
            end else begin
              r_iso   <= r_iso | w_req_mask;
              r_state <= ISO;
            end
          end
        end
        ISO: begin
          if (w_expired) begin
`ifdef LPUPF_RET_EN
            r_save  <= w_dom_mask;
            r_state <= SAVE;
`else
            r_pwr_en <= r_pwr_en & ~w_dom_mask;
            r_state  <= OFF;
`endif
          end
        end
`ifdef LPUPF_RET_EN
        SAVE: begin
          r_pwr_en <= r_pwr_en & ~w_dom_mask;
          r_state  <= OFF;
        end
        REST: begin
          r_iso   <= r_iso & ~w_dom_mask;
          r_state <= DEISO;
        end
`endif
        OFF: begin
          if (w_expired) begin
            r_pwr_stat <= r_pwr_stat & ~w_dom_mask;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end
        end
        ON: begin
          if (w_expired) begin
`ifdef LPUPF_RET_EN
            r_restore <= w_dom_mask;
            r_state   <= REST;
`else
            r_iso   <= r_iso & ~w_dom_mask;
            r_state <= DEISO;
`endif
          end
        end
        DEISO: begin
          if (w_expired) begin
            r_pwr_stat <= r_pwr_stat | w_dom_mask;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_iso      = r_iso | {NUM_DOM{i_force_iso}};
  assign o_pwr_en   = r_pwr_en;
  assign o_pwr_stat = r_pwr_stat;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule
